// File: rtl/vga_hack_fetch_if.sv
// Framebuffer read port between vga_hack_fetch (master) and the Hack SCREEN memory (slave).
interface vga_hack_fetch_if;
    logic        scr_rd_en;
    logic [12:0] scr_rd_addr;
    logic [15:0] scr_rd_data;

    modport master (output scr_rd_en, output scr_rd_addr, input scr_rd_data);
    modport slave  (input scr_rd_en, input scr_rd_addr, output scr_rd_data);
endinterface

// File: rtl/vga_hack_fetch.sv
// Maps the 512x256 1bpp Hack SCREEN into a centred window of the 640x480 frame, 3-clk pipeline.
// Optional feature: define VGA_HACK_BORDER_EN to paint the visible area outside the window with BORDER_COLOR.
module vga_hack_fetch #(
    parameter int          H_SIZE       = 10,
    parameter int          V_SIZE       = 10,
    parameter int          X_OFFSET     = 64,
    parameter int          Y_OFFSET     = 112,
    parameter logic [11:0] FG_COLOR     = 12'h000,
    parameter logic [11:0] BG_COLOR     = 12'hFFF,
    parameter logic [11:0] BORDER_COLOR = 12'h008
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              display_in,
    input  logic [H_SIZE-1:0] x_in,
    input  logic [V_SIZE-1:0] y_in,
    vga_hack_fetch_if.master  scr,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b
);

`ifdef VGA_HACK_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif
    localparam logic [11:0] OUTSIDE_COLOR = BORDER_EN ? BORDER_COLOR : 12'h000;

    if ((X_OFFSET % 16) != 0 || H_SIZE < 10 || V_SIZE < 9) begin : g_bad_config
        $error("vga_hack_fetch: X_OFFSET must be 16-aligned and H_SIZE/V_SIZE wide enough");
    end

    logic [H_SIZE-1:0] xRel;
    logic [V_SIZE-1:0] yRel;
    logic              inWin;
    logic [8:0]        rx;
    logic [7:0]        ry;

    logic        rdEn_d, rdEnS1_q, rdEnS2_q;
    logic [12:0] rdAddr_d, rdAddr_q;
    logic [3:0]  idxS1_q, idxS2_q;
    logic        inWinS1_q, inWinS2_q;
    logic        dispS1_q, dispS2_q;
    logic        hsS1_q, hsS2_q, hsS3_q;
    logic        vsS1_q, vsS2_q, vsS3_q;
    logic [15:0] wordBuf_d, wordBuf_q;
    logic        pix;
    logic [11:0] rgb_d, rgb_q;

    // Window offsets are only meaningful inside the window; outside they are forced to zero.
    assign xRel  = x_in - H_SIZE'(X_OFFSET);
    assign yRel  = y_in - V_SIZE'(Y_OFFSET);
    assign inWin = display_in
                && (x_in >= H_SIZE'(X_OFFSET)) && (xRel < H_SIZE'(512))
                && (y_in >= V_SIZE'(Y_OFFSET)) && (yRel < V_SIZE'(256));
    assign rx    = inWin ? xRel[8:0] : 9'd0;
    assign ry    = inWin ? yRel[7:0] : 8'd0;

    always_comb begin
        rdEn_d    = inWin && (rx[3:0] == 4'd0);
        rdAddr_d  = rdEn_d ? {ry, rx[8:4]} : rdAddr_q;
        wordBuf_d = rdEnS2_q ? scr.scr_rd_data : wordBuf_q;
        pix       = rdEnS2_q ? scr.scr_rd_data[idxS2_q] : wordBuf_q[idxS2_q];
        rgb_d     = 12'h000;
        if (inWinS2_q) begin
            rgb_d = pix ? FG_COLOR : BG_COLOR;
        end else if (dispS2_q) begin
            rgb_d = OUTSIDE_COLOR;
        end
    end

    // Sync stages reset high so the pins sit at the inactive level until real timing flows through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdEnS1_q  <= 1'b0;
            rdAddr_q  <= '0;
            idxS1_q   <= '0;
            inWinS1_q <= 1'b0;
            dispS1_q  <= 1'b0;
            hsS1_q    <= 1'b1;
            vsS1_q    <= 1'b1;
            rdEnS2_q  <= 1'b0;
            idxS2_q   <= '0;
            inWinS2_q <= 1'b0;
            dispS2_q  <= 1'b0;
            hsS2_q    <= 1'b1;
            vsS2_q    <= 1'b1;
            wordBuf_q <= '0;
            rgb_q     <= '0;
            hsS3_q    <= 1'b1;
            vsS3_q    <= 1'b1;
        end else begin
            rdEnS1_q  <= rdEn_d;
            rdAddr_q  <= rdAddr_d;
            idxS1_q   <= rx[3:0];
            inWinS1_q <= inWin;
            dispS1_q  <= display_in;
            hsS1_q    <= hsync_in;
            vsS1_q    <= vsync_in;
            rdEnS2_q  <= rdEnS1_q;
            idxS2_q   <= idxS1_q;
            inWinS2_q <= inWinS1_q;
            dispS2_q  <= dispS1_q;
            hsS2_q    <= hsS1_q;
            vsS2_q    <= vsS1_q;
            wordBuf_q <= wordBuf_d;
            rgb_q     <= rgb_d;
            hsS3_q    <= hsS2_q;
            vsS3_q    <= vsS2_q;
        end
    end

    assign scr.scr_rd_en   = rdEnS1_q;
    assign scr.scr_rd_addr = rdAddr_q;
    assign vga_hsync       = hsS3_q;
    assign vga_vsync       = vsS3_q;
    assign vga_r           = rgb_q[11:8];
    assign vga_g           = rgb_q[7:4];
    assign vga_b           = rgb_q[3:0];

endmodule

// File: tb/tb_vga_hack_fetch.sv
// Scoreboard bench for vga_hack_fetch: stimulus pushes expected reads/pixels, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vga_hack_fetch;
    localparam int H_SIZE = 10;
    localparam int V_SIZE = 10;
`ifdef VGA_HACK_BORDER_EN
    localparam logic [11:0] BORDER_EXP = 12'h008;
`else
    localparam logic [11:0] BORDER_EXP = 12'h000;
`endif

    typedef struct {
        int          stamp;
        logic [12:0] addr;
    } rdExp_t;

    typedef struct {
        int          stamp;
        int          x;
        int          y;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } pixExp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hsync_in = 1'b1;
    logic              vsync_in = 1'b1;
    logic              display_in = 1'b0;
    logic [H_SIZE-1:0] x_in = '0;
    logic [V_SIZE-1:0] y_in = '0;
    logic              vga_hsync, vga_vsync;
    logic [3:0]        vga_r, vga_g, vga_b;

    vga_hack_fetch_if scr ();

    vga_hack_fetch #(.H_SIZE(H_SIZE), .V_SIZE(V_SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_in (display_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .scr        (scr.master),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:8191];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          lineReads = 0;
    logic [12:0] heldAddr = '0;
    rdExp_t      rdQ[$];
    pixExp_t     pixQ[$];

    // Registered memory; unread cycles return noise so any use of unrequested data shows up.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (scr.scr_rd_en) scr.scr_rd_data <= mem[scr.scr_rd_addr];
        else               scr.scr_rd_data <= 16'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (cyc %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic applyStimulus(input int x, input int y);
        logic        disp, hs, vs, inWin;
        logic [15:0] w;
        int          rx, ry, addr;
        rdExp_t      r;
        pixExp_t     p;
        @(negedge clk);
        disp  = (x < 640) && (y < 480);
        hs    = !((x >= 656) && (x < 672));
        vs    = !((y == 490) || (y == 491));
        inWin = disp && (x >= 64) && (x < 576) && (y >= 112) && (y < 368);
        x_in       = H_SIZE'(x);
        y_in       = V_SIZE'(y);
        display_in = disp;
        hsync_in   = hs;
        vsync_in   = vs;
        p.stamp = cyc + 3;
        p.x     = x;
        p.y     = y;
        p.hs    = hs;
        p.vs    = vs;
        p.rgb   = disp ? BORDER_EXP : 12'h000;
        if (inWin) begin
            rx    = x - 64;
            ry    = y - 112;
            addr  = ry * 32 + rx / 16;
            w     = mem[addr];
            p.rgb = w[rx % 16] ? 12'h000 : 12'hFFF;
            if ((rx % 16) == 0) begin
                r.stamp = cyc + 1;
                r.addr  = 13'(addr);
                rdQ.push_back(r);
            end
        end
        pixQ.push_back(p);
    endtask

    task automatic runLine(input int y, input int xStart, input int xEnd);
        for (int x = xStart; x <= xEnd; x++) applyStimulus(x, y);
    endtask

    // Monitor: pops expectations whose output cycle has arrived.
    always @(negedge clk) begin
        rdExp_t  r;
        pixExp_t p;
        if (!rst_n) begin
            heldAddr = '0;
        end else begin
            if (rdQ.size() > 0 && rdQ[0].stamp == cyc) begin
                r = rdQ.pop_front();
                checkOutput($sformatf("rd addr %0d", r.addr), {18'd0, scr.scr_rd_en, scr.scr_rd_addr}, {18'd0, 1'b1, r.addr});
                heldAddr = r.addr;
            end else begin
                checkOutput("rd idle", {18'd0, scr.scr_rd_en, scr.scr_rd_addr}, {18'd0, 1'b0, heldAddr});
            end
            if (scr.scr_rd_en) lineReads++;
            if (pixQ.size() > 0 && pixQ[0].stamp == cyc) begin
                p = pixQ.pop_front();
                checkOutput($sformatf("pix x=%0d y=%0d", p.x, p.y),
                            {18'd0, vga_hsync, vga_vsync, vga_r, vga_g, vga_b},
                            {18'd0, p.hs, p.vs, p.rgb});
            end
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, " rd"},   {18'd0, scr.scr_rd_en, scr.scr_rd_addr}, 32'd0);
        checkOutput({tag, " sync"}, {30'd0, vga_hsync, vga_vsync}, 32'd3);
        checkOutput({tag, " rgb"},  {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    endtask

    task automatic checkLineReads(input int y, input int required);
        checkOutput($sformatf("reads line %0d", y), lineReads, required);
        lineReads = 0;
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 16'((a * 27445) ^ (a >> 2) ^ 16'h5A5A);
        mem[0]    = 16'h0001;
        mem[8191] = 16'h8000;

        repeat (3) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;

        lineReads = 0;
        runLine(111, 0, 679);
        checkLineReads(111, 0);
        runLine(112, 0, 679);
        checkLineReads(112, 32);
        runLine(113, 0, 679);
        checkLineReads(113, 32);

        runLine(114, 0, 200);
        #2 rst_n = 1'b0;
        #1 checkReset("async reset");
        rdQ.delete();
        pixQ.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lineReads = 0;
        runLine(114, 208, 679);
        checkLineReads(114, 23);

        runLine(367, 0, 679);
        checkLineReads(367, 32);
        runLine(368, 0, 679);
        checkLineReads(368, 0);
        runLine(490, 0, 679);
        runLine(491, 0, 679);
        checkLineReads(490, 0);

        repeat (6) @(negedge clk);
        checkOutput("queues drained", rdQ.size() + pixQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
